// File: rtl/reg_wr_seq.sv
// reg_wr_seq -- register write sequencer feeding a 3-to-8 register-enable decoder.
//
// Accepts write requests over a valid/ready handshake and queues them in a
// small circular FIFO. Each request is replayed as a timed bus cycle
// (SETUP -> STROBE x STROBE_CYC -> HOLD), so Addr/Data are stable for a full
// cycle on each side of WR. Completed writes are counted in wr_count.
//
// Optional feature macro: REG_WR_SEQ_MASK_EN
//   defined   : wr_mask records one bit per address written since mask_clr
//   undefined : wr_mask is tied to 8'h00 and mask_clr is ignored
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset
//   req_valid  in   write request present
//   req_addr   in   [2:0] target register index
//   req_data   in   [DW-1:0] write data
//   req_ready  out  FIFO can accept a request (from registered state only)
//   Addr       out  [2:0] registered decoder address
//   Data       out  [DW-1:0] registered write data
//   WR         out  registered write strobe, active-high
//   busy       out  FSM not idle or FIFO non-empty
//   wr_count   out  [15:0] completed writes, wraps
//   mask_clr   in   clear wr_mask on the next edge
//   wr_mask    out  [7:0] per-address written flags
module reg_wr_seq #(
  parameter int DW         = 8,
  parameter int DEPTH      = 4,
  parameter int STROBE_CYC = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  input  logic [2:0]    req_addr,
  input  logic [DW-1:0] req_data,
  output logic          req_ready,
  output logic [2:0]    Addr,
  output logic [DW-1:0] Data,
  output logic          WR,
  output logic          busy,
  output logic [15:0]   wr_count,
  input  logic          mask_clr,
  output logic [7:0]    wr_mask
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam int CW = (STROBE_CYC > 1) ? $clog2(STROBE_CYC) : 1;
  localparam int EW = DW + 3;
  localparam logic [CW-1:0] CNT_LOAD = CW'(STROBE_CYC - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [EW-1:0] mem [DEPTH];
  logic [EW-1:0] head;
  logic          full;
  logic          empty;
  logic          push;
  logic          pop;

  // Pointers carry one extra wrap bit to tell full from empty.
  assign full      = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign empty     = (wr_ptr == rd_ptr);
  assign req_ready = !full;
  // A push is gated only by full, so a pop on the same edge never frees a slot early.
  assign push      = req_valid && !full;
  // Pops happen only where Addr/Data are allowed to change: IDLE and HOLD.
  assign pop       = ((state == IDLE) || (state == HOLD)) && !empty;
  assign busy      = (state != IDLE) || !empty;
  assign head      = mem[rd_ptr[AW-1:0]];

  // FIFO storage write port; contents need no reset since pointers gate validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= {req_addr, req_data};
    end
  end

  // FIFO read/write pointers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= {PW{1'b0}};
      rd_ptr <= {PW{1'b0}};
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
    end
  end

  // Bus-cycle FSM with registered Addr/Data/WR and the completed-write counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= {CW{1'b0}};
      Addr     <= 3'd0;
      Data     <= {DW{1'b0}};
      WR       <= 1'b0;
      wr_count <= 16'd0;
    end else begin
      case (state)
        IDLE: begin
          WR <= 1'b0;
          if (pop) begin
            Addr  <= head[EW-1:DW];
            Data  <= head[DW-1:0];
            state <= SETUP;
          end
        end
        SETUP: begin
          WR    <= 1'b1;
          cnt   <= CNT_LOAD;
          state <= STROBE;
        end
        STROBE: begin
          if (cnt == {CW{1'b0}}) begin
            WR    <= 1'b0;
            state <= HOLD;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        HOLD: begin
          WR       <= 1'b0;
          wr_count <= wr_count + 16'd1;
          // Back-to-back: go straight to SETUP with the next entry.
          if (pop) begin
            Addr  <= head[EW-1:DW];
            Data  <= head[DW-1:0];
            state <= SETUP;
          end else begin
            state <= IDLE;
          end
        end
        default: begin
          WR    <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

`ifdef REG_WR_SEQ_MASK_EN
  logic [7:0] mask_set;
  logic [7:0] mask_next;

  // Set bit is OR-ed after the clear so a same-edge set survives a clear.
  always_comb begin
    mask_set  = (state == HOLD) ? (8'h01 << Addr) : 8'h00;
    mask_next = (mask_clr ? 8'h00 : wr_mask) | mask_set;
  end

  // Written-address mask register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_mask <= 8'h00;
    end else begin
      wr_mask <= mask_next;
    end
  end
`else
  logic unused_mask_clr;

  assign unused_mask_clr = mask_clr;
  assign wr_mask         = 8'h00;
`endif

endmodule

// File: doc/reg_wr_seq.md
# reg_wr_seq

Write sequencer that sits directly upstream of the 3-to-8 register-enable decoder. It accepts register write requests (address and data) over a valid/ready handshake and buffers them in a small FIFO. It replays each request as a timed bus cycle on `Addr`/`Data`/`WR`, so the decoder only ever sees a stable address while `WR` is asserted. It also counts completed writes for software and debug visibility.

## Interface
Parameters:
- `DW`, 8, width of the write data bus
- `DEPTH`, 4, request FIFO depth; power of two, ≥2
- `STROBE_CYC`, 1, clock cycles `WR` stays high per write; ≥1

Ports:
- `clk` in 1: single clock. All state changes on the rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `req_valid` in 1: a write request is presented.
- `req_addr` in 3: target register index 0–7.
- `req_data` in DW: write data.
- `req_ready` out 1: the FIFO can accept a request.
- `Addr` out 3: address to the decoder, registered.
- `Data` out DW: data to the register bank, registered.
- `WR` out 1: write strobe to the decoder, registered, active-high.
- `busy` out 1: the FSM is not IDLE, or the FIFO is non-empty.
- `wr_count` out 16: completed writes, wraps modulo 2^16.
- `mask_clr` in 1: clears `wr_mask` (see Configuration).
- `wr_mask` out 8: one bit per address written since the last clear (see Configuration).

## Operation
- Request handshake:
  - A request is accepted on a rising edge when `req_valid & req_ready`.
  - `req_ready = !fifo_full`, driven from registered state only; there is no combinational path from `req_valid`.
  - When the FIFO is full, `req_ready` is 0 and the requester must hold `req_valid`, `req_addr` and `req_data`.
- FSM states:
  - IDLE: `WR`=0. If the FIFO is non-empty, pop the head, load it into `Addr`/`Data`, and go to SETUP.
  - SETUP (1 cycle): `WR`=0 with `Addr`/`Data` stable. Go to STROBE and load the strobe counter with `STROBE_CYC-1`.
  - STROBE (`STROBE_CYC` cycles): `WR`=1. Decrement the counter. At 0, go to HOLD.
  - HOLD (1 cycle): `WR`=0 with `Addr`/`Data` unchanged. Increment `wr_count`.
    - If the FIFO is non-empty, pop and load the next entry and go to SETUP.
    - Otherwise go to IDLE.
- `Addr`/`Data` change only on the pop edge. They are never modified while `WR`=1 or during the cycles adjacent to `WR`=1.
- FIFO: circular buffer with `log2(DEPTH)+1`-bit read/write pointers, which wrap naturally.
  - Full when the low bits of the pointers are equal and the MSBs differ.
  - Empty when the pointers are fully equal.
- Simultaneous push and pop in the same edge:
  - Occupancy is unchanged.
  - Allowed at any non-full occupancy.
  - A push is never accepted while full, even if a pop occurs in the same edge.
- Reset (asynchronous, any state, including mid-STROBE):
  - FSM goes to IDLE and the FIFO is flushed.
  - `WR`=0, `Addr`=0, `Data`=0, `wr_count`=0, `wr_mask`=0.
  - `req_ready`=1 and `busy`=0.
  - A write interrupted by reset is lost and is not counted.

## Timing
- Request accepted at edge N into an empty FIFO with the FSM in IDLE:
  - Pop edge N+1: `Addr`/`Data` are valid after N+1.
  - `WR` rises after N+2 and falls after N+2+`STROBE_CYC`.
  - `wr_count` increments at edge N+3+`STROBE_CYC`.
- Throughput: one write every `STROBE_CYC+2` cycles when back-to-back. HOLD goes directly to SETUP, with no IDLE cycle in between.
- `WR` never stays high across two consecutive writes; there is always at least 2 cycles of `WR`=0 between strobes.
- The downstream decoder qualifies `WR` with `clk`. Its enables therefore pulse during the high phase of each STROBE cycle, which is stable because `Addr` was set up one full cycle earlier.

## Configuration
- Macro `REG_WR_SEQ_MASK_EN`.
  - Defined:
    - `wr_mask[Addr]` is set on the HOLD edge of each completed write.
    - `mask_clr`=1 clears the whole mask on the next edge.
    - If a clear and a set happen on the same edge, the set wins for that bit.
  - Not defined: `wr_mask` is tied to 8'h00, `mask_clr` is ignored, and no mask flops are synthesized.
- The ports are present in both builds.

## Test plan
- Reset then a single write (addr 5, data 8'hA5, `STROBE_CYC`=1):
  - `Addr`=5 and `Data`=A5 one cycle before `WR`.
  - `WR` high for exactly 1 cycle.
  - `wr_count`=1.
  - `wr_mask`=8'h20 with the macro, 8'h00 without.
- Burst of 6 requests with `req_valid` held high, DEPTH=4:
  - `req_ready` drops after the FIFO fills.
  - All 6 writes appear in order with addresses 0–5, spaced 3 cycles apart.
  - `wr_count`=6.
- Push and pop on the same edge at occupancy 2: occupancy stays 2 and no entry is lost or duplicated.
- `STROBE_CYC`=3: `WR` stays high for 3 cycles, and `Addr`/`Data` stay constant from SETUP through HOLD.
- Assert `rst` during the second STROBE cycle:
  - `WR`=0 immediately, FIFO empty, `wr_count`=0, `req_ready`=1.
  - The next request is processed normally.
- `mask_clr` on the same edge as the HOLD for addr 2: `wr_mask`=8'h04 after that edge.
